mem_arbiter: RTL

Two-requester arbiter for the adding machine's single 64×8 memory port. Lets the CPU (requester 0) share memory with a loader/debug host (requester 1), e.g. for preloading programs or inspecting results. Serialises accesses through a three-state FSM and drives one registered read or write strobe per grant. Arbitration between simultaneous requests is round-robin.

---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/mem_arbiter_if.sv | 17 +
 rtl/mem_arbiter_rr_pick2.sv | 15 +
 rtl/mem_arbiter.sv | 79 +++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: widths and FSM state encoding shared by the arbiter files
package mem_arbiter_pkg;
  localparam int ADR_W = 6;
  localparam int DAT_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and the single memory port
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;
  logic             r0_req, r1_req, r0_wr, r1_wr, r0_ack, r1_ack;
  logic [ADR_W-1:0] r0_adr, r1_adr, mem_adr;
  logic [DAT_W-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata;
  logic             mem_rd, mem_wr;
  logic [DAT_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  r0_req, r1_req, r0_wr, r1_wr, r0_adr, r1_adr, r0_wdata, r1_wdata, mem_rdata,
    output r0_ack, r1_ack, r0_rdata, r1_rdata, mem_adr, mem_rd, mem_wr, mem_wdata
  );
  modport master (
    output r0_req, r1_req, r0_wr, r1_wr, r0_adr, r1_adr, r0_wdata, r1_wdata, mem_rdata,
    input  r0_ack, r1_ack, r0_rdata, r1_rdata, mem_adr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the side not granted last wins
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       last_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);
  logic [1:0] elig;
  always_comb begin
    elig          = req_i & ~mask_i;
    grant_valid_o = |elig;
    grant_idx_o   = &elig ? ~last_i : elig[1];
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two requesters onto one memory port, one access per three cycles
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  state_e           state_q, state_d;
  logic             last_q, last_d, win_q, win_d, wr_q, wr_d;
  logic             rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
  logic [1:0]       ack_q, ack_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic             gnt_v, gnt_i, grant, sel_wr, done;

  // a requester acked this cycle is masked so a held-over req is not re-served
  rr_pick2 u_pick (
    .req_i         ({bus.r1_req, bus.r0_req}),
    .mask_i        (ack_q),
    .last_i        (last_q),
    .grant_valid_o (gnt_v),
    .grant_idx_o   (gnt_i)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      ack_q    <= '0;
      adr_q    <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      ack_q    <= ack_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    grant    = (state_q == ST_IDLE) && gnt_v;
    done     = state_q == ST_CAPTURE;
    sel_wr   = gnt_i ? bus.r1_wr : bus.r0_wr;
    state_d  = grant ? ST_ACCESS : (state_q == ST_ACCESS) ? ST_CAPTURE : ST_IDLE;
    last_d   = grant ? gnt_i : last_q;
    win_d    = grant ? gnt_i : win_q;
    wr_d     = grant ? sel_wr : wr_q;
    adr_d    = grant ? (gnt_i ? bus.r1_adr : bus.r0_adr) : adr_q;
    wdata_d  = grant ? (gnt_i ? bus.r1_wdata : bus.r0_wdata) : wdata_q;
    rd_stb_d = grant && !sel_wr;
    wr_stb_d = grant && sel_wr;
    ack_d    = done ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    rdata0_d = (done && !wr_q && !win_q) ? bus.mem_rdata : rdata0_q;
    rdata1_d = (done && !wr_q && win_q) ? bus.mem_rdata : rdata1_q;
  end

  assign bus.r0_ack    = ack_q[0];
  assign bus.r1_ack    = ack_q[1];
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.mem_adr   = adr_q;
  assign bus.mem_rd    = rd_stb_q;
  assign bus.mem_wr    = wr_stb_q;
  assign bus.mem_wdata = wdata_q;
endmodule
